// File: rtl/spi_arbiter.sv
// Round-robin arbiter and byte sequencer sharing one SPI byte engine
// between N_REQ requesters. Holds cs low across each multi-byte transaction,
// tags received bytes with their owner and keeps cs high for a fixed gap
// between transactions.
module spi_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned MAX_LEN    = 8,
    parameter int unsigned GAP_CYCLES = 4,
    localparam int unsigned IDW       = (N_REQ > 2) ? $clog2(N_REQ) : 1,
    localparam int unsigned LENW      = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*LENW-1:0] req_len,
    input  logic [N_REQ*8-1:0]    req_tx_data,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      tx_pop,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    output logic [IDW-1:0]        rx_id,
    output logic                  rx_last,
    output logic [N_REQ-1:0]      req_done,
    output logic                  spi_start,
    output logic [7:0]            spi_tx_byte,
    input  logic                  spi_done,
    input  logic [7:0]            spi_rx_byte,
    output logic                  cs
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, GAP} state_t;

    state_t           state, state_nx;
    logic [IDW-1:0]   owner, owner_nx;
    logic [IDW-1:0]   last, last_nx;
    logic [LENW-1:0]  count, count_nx;
    logic [GW-1:0]    gap_cnt, gap_cnt_nx;
    logic [N_REQ-1:0] grant_nx, tx_pop_nx, req_done_nx;
    logic [7:0]       rx_data_nx, spi_tx_byte_nx;
    logic [IDW-1:0]   rx_id_nx;
    logic             rx_valid_nx, rx_last_nx, spi_start_nx, cs_nx;

    logic             found;
    logic [IDW-1:0]   winner, cand;
    logic [LENW-1:0]  win_len, clamp_len;

    // Round-robin winner search starting just after the last owner, plus length clamp
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IDW'((32'(last) + i) % N_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        win_len = req_len[32'(winner)*LENW +: LENW];
        if (win_len == '0)
            clamp_len = LENW'(1);
        else if (32'(win_len) > MAX_LEN)
            clamp_len = LENW'(MAX_LEN);
        else
            clamp_len = win_len;
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_nx       = state;
        owner_nx       = owner;
        last_nx        = last;
        count_nx       = count;
        gap_cnt_nx     = gap_cnt;
        grant_nx       = grant;
        cs_nx          = cs;
        tx_pop_nx      = '0;
        req_done_nx    = '0;
        rx_valid_nx    = 1'b0;
        rx_last_nx     = 1'b0;
        spi_start_nx   = 1'b0;
        rx_data_nx     = rx_data;
        rx_id_nx       = rx_id;
        spi_tx_byte_nx = spi_tx_byte;

        case (state)
            IDLE: begin
                if (found) begin
                    owner_nx = winner;
                    grant_nx = N_REQ'(1) << winner;
                    count_nx = clamp_len;
                    cs_nx    = 1'b0;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                spi_start_nx      = 1'b1;
                spi_tx_byte_nx    = req_tx_data[32'(owner)*8 +: 8];
                tx_pop_nx[owner]  = 1'b1;
                state_nx          = START;
            end
            START: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (spi_done) begin
                    rx_data_nx  = spi_rx_byte;
                    rx_valid_nx = 1'b1;
                    rx_id_nx    = owner;
                    if (count > LENW'(1)) begin
                        // Back-to-back byte: next start overlaps this rx_valid
                        count_nx         = count - LENW'(1);
                        spi_start_nx     = 1'b1;
                        spi_tx_byte_nx   = req_tx_data[32'(owner)*8 +: 8];
                        tx_pop_nx[owner] = 1'b1;
                        state_nx         = START;
                    end else begin
                        rx_last_nx         = 1'b1;
                        req_done_nx[owner] = 1'b1;
                        cs_nx              = 1'b1;
                        grant_nx           = '0;
                        last_nx            = owner;
                        gap_cnt_nx         = GW'(GAP_CYCLES - 1);
                        state_nx           = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0)
                    state_nx = IDLE;
                else
                    gap_cnt_nx = gap_cnt - GW'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers; pointer resets so requester 0 is searched first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            last        <= IDW'(N_REQ - 1);
            count       <= '0;
            gap_cnt     <= '0;
            grant       <= '0;
            cs          <= 1'b1;
            tx_pop      <= '0;
            req_done    <= '0;
            rx_valid    <= 1'b0;
            rx_last     <= 1'b0;
            spi_start   <= 1'b0;
            rx_data     <= '0;
            rx_id       <= '0;
            spi_tx_byte <= '0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            last        <= last_nx;
            count       <= count_nx;
            gap_cnt     <= gap_cnt_nx;
            grant       <= grant_nx;
            cs          <= cs_nx;
            tx_pop      <= tx_pop_nx;
            req_done    <= req_done_nx;
            rx_valid    <= rx_valid_nx;
            rx_last     <= rx_last_nx;
            spi_start   <= spi_start_nx;
            rx_data     <= rx_data_nx;
            rx_id       <= rx_id_nx;
            spi_tx_byte <= spi_tx_byte_nx;
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: byte-engine model, requester data model, a table of
// single transactions, and hand sequences for spurious done, mid-transaction
// reset and continuous contention.
module tb_spi_arbiter;

    localparam int unsigned N_REQ      = 2;
    localparam int unsigned MAX_LEN    = 8;
    localparam int unsigned GAP_CYCLES = 4;
    localparam int          DLY        = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [7:0]  req_len;
    logic [15:0] req_tx_data;
    logic [1:0]  grant, tx_pop, req_done;
    logic [7:0]  rx_data, spi_tx_byte;
    logic [7:0]  spi_rx_byte = 8'h00;
    logic        rx_valid, rx_last, spi_start, cs;
    logic [0:0]  rx_id;
    logic        eng_done = 1'b0;
    logic        spur_done;

    logic [7:0]  tx_base [2];
    int          pop_n [2];

    typedef struct {
        logic [1:0] rq;
        logic [3:0] l0;
        logic [3:0] l1;
        logic [7:0] b0;
        logic [7:0] b1;
        int         own;
        int         nb;
    } vec_t;

    // Monitor state (written only by the monitor process)
    int          cyc = 0;
    int          eng_cnt = 0;
    logic [7:0]  eng_tx = 8'h00;
    logic [7:0]  st_q [$];
    logic [9:0]  rx_q [$];
    logic [1:0]  dn_q [$];
    logic [1:0]  gr_q [$];
    int          gap_q [$];
    int          last_cyc = 0;
    int          cs_err = 0, grant_err = 0, dead_err = 0, stray_done = 0;
    logic [1:0]  prev_grant = 2'b00;

    int passed = 0;
    int total  = 0;

    assign req_tx_data = {tx_base[1] + 8'(pop_n[1]), tx_base[0] + 8'(pop_n[0])};

    always #5 clk = ~clk;

    spi_arbiter #(
        .N_REQ(N_REQ),
        .MAX_LEN(MAX_LEN),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_len(req_len),
        .req_tx_data(req_tx_data),
        .grant(grant),
        .tx_pop(tx_pop),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_id(rx_id),
        .rx_last(rx_last),
        .req_done(req_done),
        .spi_start(spi_start),
        .spi_tx_byte(spi_tx_byte),
        .spi_done(eng_done | spur_done),
        .spi_rx_byte(spi_rx_byte),
        .cs(cs)
    );

    // Engine model and protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            eng_cnt    = 0;
            eng_done   = 1'b0;
            prev_grant = 2'b00;
        end else begin
            eng_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done    = 1'b1;
                    spi_rx_byte = {eng_tx[3:0], eng_tx[3:0]};
                end
            end
            if (spi_start) begin
                eng_cnt = DLY;
                eng_tx  = spi_tx_byte;
                st_q.push_back(spi_tx_byte);
            end
            for (int i = 0; i < 2; i++)
                if (tx_pop[i]) pop_n[i]++;
            if (rx_valid) begin
                rx_q.push_back({rx_last, rx_id, rx_data});
                dn_q.push_back(req_done);
                if (!rx_last && !spi_start) dead_err++;
                if (rx_last) last_cyc = cyc;
            end else if (req_done != 2'b00) begin
                stray_done++;
            end
            if (grant != 2'b00 && cs) cs_err++;
            if (prev_grant != 2'b00 && grant != 2'b00 && grant != prev_grant) grant_err++;
            if (prev_grant == 2'b00 && grant != 2'b00) begin
                gr_q.push_back(grant);
                gap_q.push_back(cyc - last_cyc);
            end
            prev_grant = grant;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    // Wait for the req_done pulse with a cycle budget; returns 1 if seen
    task automatic wait_done(output int ok);
        int k;
        k = 0;
        ok = 0;
        while (k < 400 && ok == 0) begin
            @(negedge clk);
            k++;
            if (req_done != 2'b00) ok = 1;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int s0, r0, p0, q0, k, ok;
        logic [7:0] b, e;
        logic [9:0] r;
        s0 = st_q.size();
        r0 = rx_q.size();
        p0 = pop_n[v.own];
        q0 = pop_n[1 - v.own];
        tx_base[0] = v.b0 - 8'(pop_n[0]);
        tx_base[1] = v.b1 - 8'(pop_n[1]);
        req_len = {v.l1, v.l0};
        req = v.rq;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (grant == 2'b00 && k < 50);
        check($sformatf("v%0d grant_latency", idx), k, 1);
        check($sformatf("v%0d grant", idx), int'(grant), 1 << v.own);
        req = 2'b00;
        @(negedge clk);
        check($sformatf("v%0d first_start", idx), int'(spi_start), 1);
        wait_done(ok);
        check($sformatf("v%0d done_seen", idx), ok, 1);
        if (ok == 1) check($sformatf("v%0d done_owner", idx), int'(req_done), 1 << v.own);
        repeat (10) @(negedge clk);
        check($sformatf("v%0d starts", idx), st_q.size() - s0, v.nb);
        check($sformatf("v%0d rx_count", idx), rx_q.size() - r0, v.nb);
        check($sformatf("v%0d pops_owner", idx), pop_n[v.own] - p0, v.nb);
        check($sformatf("v%0d pops_other", idx), pop_n[1 - v.own] - q0, 0);
        b = (v.own == 1) ? v.b1 : v.b0;
        for (int j = 0; j < v.nb; j++) begin
            e = b + 8'(j);
            if (s0 + j < st_q.size())
                check($sformatf("v%0d tx_byte%0d", idx, j), int'(st_q[s0 + j]), int'(e));
            if (r0 + j < rx_q.size()) begin
                r = rx_q[r0 + j];
                check($sformatf("v%0d rx_data%0d", idx, j), int'(r[7:0]), int'({e[3:0], e[3:0]}));
                check($sformatf("v%0d rx_id%0d", idx, j), int'(r[8]), v.own);
                check($sformatf("v%0d rx_last%0d", idx, j), int'(r[9]), (j == v.nb - 1) ? 1 : 0);
                check($sformatf("v%0d req_done%0d", idx, j), int'(dn_q[r0 + j]),
                      (j == v.nb - 1) ? (1 << v.own) : 0);
            end
        end
    endtask

    initial begin
        vec_t vt [8];
        int s0, r0, g0, k, ok, ns;

        vt[0] = '{rq: 2'b01, l0: 4'd3,  l1: 4'd0, b0: 8'hA1, b1: 8'h00, own: 0, nb: 3};
        vt[1] = '{rq: 2'b10, l0: 4'd0,  l1: 4'd0, b0: 8'h00, b1: 8'h50, own: 1, nb: 1};
        vt[2] = '{rq: 2'b01, l0: 4'd15, l1: 4'd0, b0: 8'h30, b1: 8'h00, own: 0, nb: 8};
        vt[3] = '{rq: 2'b10, l0: 4'd0,  l1: 4'd8, b0: 8'h00, b1: 8'hC0, own: 1, nb: 8};
        vt[4] = '{rq: 2'b01, l0: 4'd1,  l1: 4'd0, b0: 8'h77, b1: 8'h00, own: 0, nb: 1};
        vt[5] = '{rq: 2'b11, l0: 4'd2,  l1: 4'd2, b0: 8'h10, b1: 8'h20, own: 1, nb: 2};
        vt[6] = '{rq: 2'b11, l0: 4'd1,  l1: 4'd1, b0: 8'h40, b1: 8'h60, own: 0, nb: 1};
        vt[7] = '{rq: 2'b01, l0: 4'd2,  l1: 4'd0, b0: 8'h0E, b1: 8'h00, own: 0, nb: 2};

        reset = 1'b1;
        req = 2'b00;
        req_len = 8'h00;
        spur_done = 1'b0;
        tx_base[0] = 8'h00;
        tx_base[1] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset cs", int'(cs), 1);
        check("reset grant", int'(grant), 0);
        check("reset rx_valid", int'(rx_valid), 0);
        check("reset spi_start", int'(spi_start), 0);
        check("reset rx_data", int'(rx_data), 0);
        check("reset spi_tx_byte", int'(spi_tx_byte), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Spurious done in IDLE, SETUP and GAP
        r0 = rx_q.size();
        s0 = st_q.size();
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_done rx", rx_q.size() - r0, 0);
        check("idle_done cs", int'(cs), 1);
        check("idle_done grant", int'(grant), 0);
        tx_base[0] = 8'h96 - 8'(pop_n[0]);
        req_len = 8'h01;
        req = 2'b01;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (grant == 2'b00 && k < 50);
        spur_done = 1'b1;
        req = 2'b00;
        @(negedge clk);
        spur_done = 1'b0;
        wait_done(ok);
        check("spur done_seen", ok, 1);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (10) @(negedge clk);
        check("spur rx_count", rx_q.size() - r0, 1);
        check("spur starts", st_q.size() - s0, 1);
        if (rx_q.size() > r0) check("spur rx_data", int'(rx_q[r0][7:0]), 8'h66);

        // Reset in WAIT of byte 2 of a 4-byte transaction on requester 1
        tx_base[1] = 8'hE0 - 8'(pop_n[1]);
        req_len = 8'h40;
        req = 2'b10;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (grant == 2'b00 && k < 50);
        req = 2'b00;
        ns = 0;
        k = 0;
        while (ns < 2 && k < 100) begin
            if (spi_start) ns++;
            if (ns < 2) @(negedge clk);
            k++;
        end
        check("rst second_start", ns, 2);
        @(negedge clk);
        check("rst pre_cs", int'(cs), 0);
        #2 reset = 1'b1;
        #1;
        check("rst async cs", int'(cs), 1);
        check("rst async grant", int'(grant), 0);
        check("rst async spi_start", int'(spi_start), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Continuous contention after reset: 0,1,0,1 with fixed gap
        g0 = gr_q.size();
        req_len = 8'h11;
        req = 2'b11;
        k = 0;
        while (gr_q.size() < g0 + 4 && k < 600) begin
            @(negedge clk);
            k++;
        end
        req = 2'b00;
        repeat (30) @(negedge clk);
        check("rr grants_seen", (gr_q.size() >= g0 + 4) ? 1 : 0, 1);
        for (int j = 0; j < 4; j++)
            if (g0 + j < gr_q.size())
                check($sformatf("rr grant%0d", j), int'(gr_q[g0 + j]), (j % 2 == 0) ? 1 : 2);
        for (int j = 1; j < 4; j++)
            if (g0 + j < gap_q.size())
                check($sformatf("rr gap%0d", j), gap_q[g0 + j], GAP_CYCLES + 1);

        check("cs_low_while_granted", cs_err, 0);
        check("grant_stable", grant_err, 0);
        check("no_dead_cycle", dead_err, 0);
        check("no_stray_req_done", stray_done, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
